// File: rtl/delay_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_sched_pkg
// Description : Shared definitions for the delay scheduler: FSM state
//               encoding, default parameter values, owner index width and
//               the round-robin index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_sched_pkg;

  // Default parameter values
  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Width of the owner index (covers up to 8 requesters)
  localparam int OWNER_W = 3;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Requester index that is 'step' positions after 'base', wrapping at n.
  function automatic logic [OWNER_W-1:0] rr_index(
    input logic [OWNER_W-1:0] base,
    input int                 step,
    input int                 n
  );
    return OWNER_W'((int'(base) + step) % n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_scheduler_if
// Description : Requester-side bus of the delay scheduler.
//               master : requester control logic (drives req/delay)
//               slave  : delay_scheduler (drives gnt/done/busy/owner/cnt)
// Signals     : req   [N_REQ]        level request per requester
//               delay [N_REQ*CNT_W]  per-requester delay, slice i at i*CNT_W
//               gnt   [N_REQ]        one-hot grant pulse
//               done  [N_REQ]        one-hot completion pulse
//               busy                 counter owned
//               owner [OWNER_W]      current / last-served requester
//               cnt   [CNT_W]        current counter value
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_scheduler_if
  import delay_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] delay;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [OWNER_W-1:0]     owner;
  logic [CNT_W-1:0]       cnt;

  modport master (
    output req,
    output delay,
    input  gnt,
    input  done,
    input  busy,
    input  owner,
    input  cnt
  );

  modport slave (
    input  req,
    input  delay,
    output gnt,
    output done,
    output busy,
    output owner,
    output cnt
  );

endinterface
`default_nettype wire

// File: rtl/delay_scheduler_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter
// Description : CNT_W-bit up-counter with synchronous clear and count
//               enable. term_o flags that the count has reached load_i-1,
//               i.e. the last tick of a delay of load_i cycles.
// Ports       : clock_i  - clock
//               reset_i  - asynchronous active-high reset
//               clear_i  - synchronous clear to zero (wins over enable)
//               enable_i - increment by one
//               load_i   - delay value the terminal flag compares against
//               cnt_o    - current count
//               term_o   - cnt_o == load_i - 1
// Revision    : 1.0 - initial release
// ============================================================================
module tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] load_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  // With load_i == 0 this compares against all-ones; the scheduler never
  // counts in that case, so the flag is simply ignored.
  assign term_o = (cnt_q == (load_i - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : delay_scheduler
// Description : Time-shares one tick counter among N_REQ requesters. A
//               round-robin arbiter grants the counter in IDLE, the delay
//               of the winner is latched and counted out, and a one-cycle
//               done pulse is returned to that requester.
// Ports       : clock_i - clock, rising edge
//               reset_i - asynchronous active-high reset
//               bus     - delay_scheduler_if.slave (req/delay in,
//                         gnt/done/busy/owner/cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  delay_scheduler_if.slave  bus
);

  // Requests and delays are widened to the full owner index range so the
  // arbiter can index them with an OWNER_W-bit value directly.
  localparam int REQ_EXT_W = 1 << OWNER_W;

  logic [1:0]         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0]   dly_q,   dly_d;
  logic [N_REQ-1:0]   gnt_q,   gnt_d;

  logic [REQ_EXT_W-1:0] req_ext;
  logic [CNT_W-1:0]     dly_arr [REQ_EXT_W];

  logic               win_found;
  logic [OWNER_W-1:0] win_idx;

  logic               cnt_clear;
  logic               cnt_enable;
  logic               cnt_term;
  logic [CNT_W-1:0]   cnt_val;
  logic [N_REQ-1:0]   done_w;

  // --------------------------------------------------------------------------
  // Input unpacking
  // --------------------------------------------------------------------------
  assign req_ext = REQ_EXT_W'(bus.req);

  for (genvar i = 0; i < REQ_EXT_W; i++) begin : g_dly
    if (i < N_REQ) begin : g_used
      assign dly_arr[i] = bus.delay[i*CNT_W +: CNT_W];
    end else begin : g_unused
      assign dly_arr[i] = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first set request after the last-served one, so the
  // requester just served is always considered last.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req_ext[rr_index(last_q, k, N_REQ)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(last_q, k, N_REQ);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scheduler FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    dly_d   = dly_q;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          dly_d   = dly_arr[win_idx];
          gnt_d   = N_REQ'(1) << win_idx;
          // A zero delay skips counting and completes in the grant cycle.
          state_d = (dly_arr[win_idx] != '0) ? ST_COUNT : ST_DONE;
        end
      end
      ST_COUNT: begin
        if (cnt_term) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OWNER_W'(N_REQ - 1);
      dly_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      dly_q   <= dly_d;
      gnt_q   <= gnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Shared counter: runs only in COUNT, holds at D-1 on the terminal tick and
  // returns to zero as the DONE cycle ends.
  // --------------------------------------------------------------------------
  assign cnt_clear  = (state_q == ST_DONE);
  assign cnt_enable = (state_q == ST_COUNT) && !cnt_term;

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear_i  (cnt_clear),
    .enable_i (cnt_enable),
    .load_i   (dly_q),
    .cnt_o    (cnt_val),
    .term_o   (cnt_term)
  );

  // --------------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // --------------------------------------------------------------------------
  always_comb begin
    done_w = '0;
    if (state_q == ST_DONE) begin
      done_w = N_REQ'(1) << owner_q;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_w;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.owner = owner_q;
  assign bus.cnt   = cnt_val;

endmodule
`default_nettype wire

// File: tb/tb_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_scheduler
// Description : Self-checking bench for delay_scheduler. A table of
//               transactions (request pattern, delays, expected winner and
//               delay) is applied back to back; hand-written sequences cover
//               late arrival, delay change, request withdrawal and reset
//               during a count. Outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;

  int n_checks;
  int n_fails;

  delay_scheduler_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

  delay_scheduler #(
    .N_REQ (N_REQ),
    .CNT_W (CNT_W)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] dly;    // {d3, d2, d1, d0}
    int          owner;  // expected winner
    int          d;      // expected latched delay
    bit          drop;   // winner drops its request after the grant
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eg,
                            input logic [3:0] ed, input logic eb,
                            input logic [2:0] eo, input logic [7:0] ec);
    chk(tag, "gnt",   32'(bus.gnt),   32'(eg));
    chk(tag, "done",  32'(bus.done),  32'(ed));
    chk(tag, "busy",  32'(bus.busy),  32'(eb));
    chk(tag, "owner", 32'(bus.owner), 32'(eo));
    chk(tag, "cnt",   32'(bus.cnt),   32'(ec));
  endtask

  // Called on a falling edge with the scheduler in IDLE; returns on the
  // falling edge of the IDLE cycle that follows the done pulse.
  task automatic txn(input string name, input logic [3:0] r,
                     input logic [31:0] dl, input int own, input int d,
                     input bit drop);
    logic [3:0] oh;
    logic [7:0] ecnt;
    oh = 4'b0001 << own;
    bus.req   = r;
    bus.delay = dl;
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      if (k < d) ecnt = 8'(k);
      else       ecnt = (d == 0) ? 8'd0 : 8'(d - 1);
      check_outs($sformatf("%s c%0d", name, k),
                 (k == 0) ? oh : 4'b0000,
                 (k == d) ? oh : 4'b0000,
                 1'b1, 3'(own), ecnt);
      if (k == 0 && drop) bus.req[own] = 1'b0;
    end
    @(negedge clk);
    check_outs($sformatf("%s idle", name), 4'b0000, 4'b0000, 1'b0,
               3'(own), 8'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset last = 3, so requester 0 has first priority.
    vecs[0]  = '{4'b0100, {8'd0, 8'd5, 8'd0, 8'd0},   2, 5,   1'b1};
    vecs[1]  = '{4'b0010, {8'd0, 8'd0, 8'd0, 8'd0},   1, 0,   1'b1};
    vecs[2]  = '{4'b1000, {8'd1, 8'd0, 8'd0, 8'd0},   3, 1,   1'b1};
    vecs[3]  = '{4'b1111, {8'd2, 8'd2, 8'd2, 8'd2},   0, 2,   1'b0};
    vecs[4]  = '{4'b1111, {8'd2, 8'd2, 8'd2, 8'd2},   1, 2,   1'b0};
    vecs[5]  = '{4'b1111, {8'd2, 8'd2, 8'd2, 8'd2},   2, 2,   1'b0};
    vecs[6]  = '{4'b1111, {8'd2, 8'd2, 8'd2, 8'd2},   3, 2,   1'b0};
    vecs[7]  = '{4'b1111, {8'd2, 8'd2, 8'd2, 8'd2},   0, 2,   1'b0};
    vecs[8]  = '{4'b0011, {8'd0, 8'd0, 8'd1, 8'd3},   1, 1,   1'b1};
    vecs[9]  = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd3},   0, 3,   1'b1};
    vecs[10] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd4},   0, 4,   1'b1};
    vecs[11] = '{4'b1001, {8'd7, 8'd0, 8'd0, 8'd6},   3, 7,   1'b1};
    vecs[12] = '{4'b0101, {8'd0, 8'd1, 8'd0, 8'd6},   0, 6,   1'b1};
    vecs[13] = '{4'b0100, {8'd0, 8'd255, 8'd0, 8'd0}, 2, 255, 1'b1};

    rst       = 1'b1;
    bus.req   = '0;
    bus.delay = '0;
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 4'b0000, 4'b0000, 1'b0, 3'd0, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check_outs("idle no req", 4'b0000, 4'b0000, 1'b0, 3'd0, 8'd0);

    for (int i = 0; i < NV; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].dly, vecs[i].owner,
          vecs[i].d, vecs[i].drop);
    end

    // Late arrival of req[3] and delay[0] change while requester 0 counts.
    bus.req   = 4'b0001;
    bus.delay = {8'd1, 8'd0, 8'd0, 8'd4};
    @(negedge clk);
    check_outs("late c0", 4'b0001, 4'b0000, 1'b1, 3'd0, 8'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    check_outs("late c1", 4'b0000, 4'b0000, 1'b1, 3'd0, 8'd1);
    bus.req   = 4'b1000;
    bus.delay = {8'd1, 8'd0, 8'd0, 8'd9};
    @(negedge clk);
    check_outs("late c2", 4'b0000, 4'b0000, 1'b1, 3'd0, 8'd2);
    @(negedge clk);
    check_outs("late c3", 4'b0000, 4'b0000, 1'b1, 3'd0, 8'd3);
    @(negedge clk);
    check_outs("late done", 4'b0000, 4'b0001, 1'b1, 3'd0, 8'd3);
    @(negedge clk);
    check_outs("late idle", 4'b0000, 4'b0000, 1'b0, 3'd0, 8'd0);
    txn("late r3", 4'b1000, {8'd1, 8'd0, 8'd0, 8'd9}, 3, 1, 1'b1);

    // req[1] rises and drops again while requester 0 counts: no grant.
    bus.req   = 4'b0001;
    bus.delay = {8'd0, 8'd0, 8'd0, 8'd2};
    @(negedge clk);
    check_outs("wd c0", 4'b0001, 4'b0000, 1'b1, 3'd0, 8'd0);
    bus.req = 4'b0010;
    @(negedge clk);
    check_outs("wd c1", 4'b0000, 4'b0000, 1'b1, 3'd0, 8'd1);
    bus.req = 4'b0000;
    @(negedge clk);
    check_outs("wd done", 4'b0000, 4'b0001, 1'b1, 3'd0, 8'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_outs($sformatf("wd idle%0d", k), 4'b0000, 4'b0000, 1'b0,
                 3'd0, 8'd0);
    end
    txn("pre rst", 4'b0010, {8'd0, 8'd0, 8'd0, 8'd0}, 1, 0, 1'b1);

    // Reset during a count at cnt == 3 (last served is 1, so without a
    // reset of the priority requester 3 would win 4'b1010).
    bus.req   = 4'b0001;
    bus.delay = {8'd0, 8'd0, 8'd0, 8'd10};
    @(negedge clk);
    check_outs("rst c0", 4'b0001, 4'b0000, 1'b1, 3'd0, 8'd0);
    bus.req = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_outs($sformatf("rst c%0d", k), 4'b0000, 4'b0000, 1'b1,
                 3'd0, 8'(k));
    end
    rst = 1'b1;
    #1;
    check_outs("rst async", 4'b0000, 4'b0000, 1'b0, 3'd0, 8'd0);
    bus.req = 4'b1010;
    @(negedge clk);
    check_outs("rst held", 4'b0000, 4'b0000, 1'b0, 3'd0, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check_outs("rst first", 4'b0010, 4'b0010, 1'b1, 3'd1, 8'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    check_outs("rst idle", 4'b0000, 4'b0000, 1'b0, 3'd1, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
